// File: rtl/fp51_int_pkg.sv
// Shared constants for the FP51 interrupt controller: FSM encodings, default SFR map, vector helper.
package fp51_int_pkg;

    typedef logic [1:0] int_state_t;

    localparam int_state_t ST_IDLE = 2'd0;
    localparam int_state_t ST_ARB  = 2'd1;
    localparam int_state_t ST_FIRE = 2'd2;
    localparam int_state_t ST_HOLD = 2'd3;

    localparam logic [7:0] DEF_ADDR_IE    = 8'hA8;
    localparam logic [7:0] DEF_ADDR_IP    = 8'hB8;
    localparam logic [7:0] DEF_ADDR_IPH   = 8'hB7;
    localparam logic [7:0] DEF_ADDR_IMODE = 8'hC8;
    localparam logic [7:0] DEF_ADDR_IFLAG = 8'hC9;

    localparam int unsigned IDX_W = 3;

    // Vector address of source idx; 8-bit arithmetic wraps on purpose.
    function automatic logic [7:0] vector_of(input logic [7:0] base,
                                             input logic [7:0] stride,
                                             input logic [IDX_W-1:0] idx);
        return 8'(base + 8'(idx) * stride);
    endfunction

endpackage

// File: rtl/fp51_int_arbiter.sv
// Combinational priority pick: highest level wins, ties resolve to the lowest source index.
module fp51_int_arbiter
    import fp51_int_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned LVL_W   = 1
) (
    input  logic [NUM_SRC-1:0]       pending,
    input  logic [NUM_SRC*LVL_W-1:0] levels,
    output logic                     valid_c,
    output logic [IDX_W-1:0]         idx_c,
    output logic [LVL_W-1:0]         level_c
);

    // Ascending scan with strict '>' keeps the lowest index on equal levels.
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        level_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && (!valid_c || (levels[i*LVL_W +: LVL_W] > level_c))) begin
                valid_c = 1'b1;
                idx_c   = IDX_W'(i);
                level_c = levels[i*LVL_W +: LVL_W];
            end
        end
    end

endmodule

// File: rtl/fp51_int_ctrl.sv
// FP51 interrupt controller: source sync, SFR block, in-service tracking and grant FSM.
module fp51_int_ctrl
    import fp51_int_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 8,
    parameter int unsigned NUM_LEVELS    = 2,
    parameter logic [7:0]  VECTOR_BASE   = 8'h03,
    parameter logic [7:0]  VECTOR_STRIDE = 8'h08,
    parameter int unsigned HOLDOFF       = 2,
    parameter logic [7:0]  ADDR_IE       = DEF_ADDR_IE,
    parameter logic [7:0]  ADDR_IP       = DEF_ADDR_IP,
    parameter logic [7:0]  ADDR_IPH      = DEF_ADDR_IPH,
    parameter logic [7:0]  ADDR_IMODE    = DEF_ADDR_IMODE,
    parameter logic [7:0]  ADDR_IFLAG    = DEF_ADDR_IFLAG,
    localparam int unsigned LVL_W        = (NUM_LEVELS == 4) ? 2 : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               WB_RD_STB_I,
    input  logic [7:0]         WB_RD_ADR_I,
    output logic [7:0]         WB_RD_DAT_O,
    output logic               WB_RD_ACK_O,
    input  logic               WB_WR_STB_I,
    input  logic               WB_WR_WE_I,
    input  logic [7:0]         WB_WR_ADR_I,
    input  logic [7:0]         WB_WR_DAT_I,
    output logic               WB_WR_ACK_O,
    output logic               int_gen,
    output logic [7:0]         int_addr,
    input  logic               interrupt_return,
    output logic [LVL_W:0]     int_active_level
);

    localparam logic [7:0] SRC_MASK  = 8'((9'd1 << NUM_SRC) - 9'd1);
    localparam logic [7:0] IE_MASK   = SRC_MASK | 8'h80;
    localparam logic [7:0] IPH_MASK  = (NUM_LEVELS == 4) ? SRC_MASK : 8'h00;
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    logic [NUM_SRC-1:0] s1, s2, s3;
    logic [7:0] ie, ip, iph, imode, flag_q, flag_d;
    logic [7:0] s2_w, edge_w, flag_live, pend8, rd_mux, hold_q;
    logic [NUM_LEVELS-1:0] isr, isr_d;
    logic [NUM_SRC-1:0][LVL_W-1:0] lvl_of;
    int_state_t state_q, state_d;
    logic [IDX_W-1:0] win_idx_q, arb_idx;
    logic [LVL_W-1:0] win_lvl_q, arb_lvl, cur_lvl;
    logic [7:0] win_vec_q;
    logic arb_valid, cur_valid, ea, fire;
    logic wr_en, wr_ie, wr_ip, wr_iph, wr_imode, wr_iflag, wr_hit, rd_hit;

    // Index of the highest set in-service bit.
    function automatic logic [LVL_W-1:0] top_lvl(input logic [NUM_LEVELS-1:0] v);
        logic [LVL_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
            if (v[i]) r = LVL_W'(i);
        end
        return r;
    endfunction

    assign s2_w      = 8'(s2);
    assign edge_w    = 8'(s2 & ~s3) & imode;
    assign flag_live = (flag_q & imode) | (s2_w & ~imode & SRC_MASK);
    assign ea        = ie[7];
    assign cur_valid = |isr;
    assign cur_lvl   = top_lvl(isr);
    assign fire      = (state_q == ST_FIRE);

    always_comb begin
        pend8 = 8'h00;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            lvl_of[i] = LVL_W'({iph[i], ip[i]});
            pend8[i]  = flag_live[i] & ie[i] & ea & (!cur_valid || (lvl_of[i] > cur_lvl));
        end
    end

    fp51_int_arbiter #(
        .NUM_SRC (NUM_SRC),
        .LVL_W   (LVL_W)
    ) u_arb (
        .pending (pend8[NUM_SRC-1:0]),
        .levels  (lvl_of),
        .valid_c (arb_valid),
        .idx_c   (arb_idx),
        .level_c (arb_lvl)
    );

    assign wr_en    = WB_WR_STB_I & WB_WR_WE_I;
    assign wr_ie    = wr_en && (WB_WR_ADR_I == ADDR_IE);
    assign wr_ip    = wr_en && (WB_WR_ADR_I == ADDR_IP);
    assign wr_iph   = wr_en && (WB_WR_ADR_I == ADDR_IPH);
    assign wr_imode = wr_en && (WB_WR_ADR_I == ADDR_IMODE);
    assign wr_iflag = wr_en && (WB_WR_ADR_I == ADDR_IFLAG);
    assign wr_hit   = wr_ie | wr_ip | wr_iph | wr_imode | wr_iflag;

    always_comb begin
        rd_hit = WB_RD_STB_I;
        rd_mux = 8'h00;
        case (WB_RD_ADR_I)
            ADDR_IE:    rd_mux = ie;
            ADDR_IP:    rd_mux = ip;
            ADDR_IPH:   rd_mux = iph;
            ADDR_IMODE: rd_mux = imode;
            ADDR_IFLAG: rd_mux = flag_live;
            default:    rd_hit = 1'b0;
        endcase
    end

    // Edge flags: software write, then grant clear, then hardware edge (edge beats a clear).
    always_comb begin
        flag_d = flag_q;
        if (wr_iflag) flag_d = WB_WR_DAT_I;
        if (fire) flag_d[win_idx_q] = 1'b0;
        flag_d = (flag_d | edge_w) & imode;
    end

    // RETI clears before a same-cycle grant sets.
    always_comb begin
        isr_d = isr;
        if (interrupt_return && cur_valid) isr_d[cur_lvl] = 1'b0;
        if (fire) isr_d[win_lvl_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_valid) state_d = ST_ARB;
            ST_ARB:  state_d = pend8[win_idx_q] ? ST_FIRE : ST_IDLE;
            ST_FIRE: state_d = ST_HOLD;
            ST_HOLD: if (hold_q == HOLD_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            ie <= 8'h00;
            ip <= 8'h00;
            iph <= 8'h00;
            imode <= 8'h00;
            flag_q <= 8'h00;
            isr <= '0;
            state_q <= ST_IDLE;
            win_idx_q <= '0;
            win_lvl_q <= '0;
            win_vec_q <= 8'h00;
            hold_q <= 8'h00;
        end else begin
            s1 <= src_in;
            s2 <= s1;
            s3 <= s2;
            if (wr_ie) ie <= WB_WR_DAT_I & IE_MASK;
            if (wr_ip) ip <= WB_WR_DAT_I & SRC_MASK;
            if (wr_iph) iph <= WB_WR_DAT_I & IPH_MASK;
            if (wr_imode) imode <= WB_WR_DAT_I & SRC_MASK;
            flag_q <= flag_d;
            isr <= isr_d;
            state_q <= state_d;
            if (state_q == ST_IDLE && arb_valid) begin
                win_idx_q <= arb_idx;
                win_lvl_q <= arb_lvl;
                win_vec_q <= vector_of(VECTOR_BASE, VECTOR_STRIDE, arb_idx);
            end
            hold_q <= (state_q == ST_HOLD) ? 8'(hold_q + 8'd1) : 8'h00;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_gen <= 1'b0;
            int_addr <= 8'h00;
            int_active_level <= '0;
            WB_WR_ACK_O <= 1'b0;
            WB_RD_ACK_O <= 1'b0;
            WB_RD_DAT_O <= 8'h00;
        end else begin
            int_gen <= (state_d == ST_FIRE);
            if (state_d == ST_FIRE) int_addr <= win_vec_q;
            int_active_level <= {|isr_d, top_lvl(isr_d)};
            WB_WR_ACK_O <= wr_hit;
            WB_RD_ACK_O <= rd_hit;
            WB_RD_DAT_O <= rd_hit ? rd_mux : 8'h00;
        end
    end

endmodule

// File: tb/tb_fp51_int_ctrl.sv
// Directed bench for fp51_int_ctrl: default instance plus a 3-source, 4-level instance.
module tb_fp51_int_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic [7:0] src1;
    logic [2:0] src4;
    logic sel, rd_stb, wr_stb, wr_we, ret;
    logic [7:0] rd_adr, wr_adr, wr_dat;

    logic [7:0] rdat1, rdat4, iaddr1, iaddr4;
    logic rack1, rack4, wack1, wack4, gen1, gen4;
    logic [1:0] lvl1;
    logic [2:0] lvl4;

    logic gen, rack, wack;
    logic [7:0] rdat, iaddr;
    logic [2:0] lvl;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign gen   = sel ? gen4 : gen1;
    assign rack  = sel ? rack4 : rack1;
    assign wack  = sel ? wack4 : wack1;
    assign rdat  = sel ? rdat4 : rdat1;
    assign iaddr = sel ? iaddr4 : iaddr1;
    assign lvl   = sel ? lvl4 : {1'b0, lvl1};

    fp51_int_ctrl dut (
        .clk(clk), .reset_n(reset_n), .src_in(src1),
        .WB_RD_STB_I(rd_stb & ~sel), .WB_RD_ADR_I(rd_adr), .WB_RD_DAT_O(rdat1), .WB_RD_ACK_O(rack1),
        .WB_WR_STB_I(wr_stb & ~sel), .WB_WR_WE_I(wr_we), .WB_WR_ADR_I(wr_adr), .WB_WR_DAT_I(wr_dat),
        .WB_WR_ACK_O(wack1), .int_gen(gen1), .int_addr(iaddr1),
        .interrupt_return(ret & ~sel), .int_active_level(lvl1)
    );

    fp51_int_ctrl #(.NUM_SRC(3), .NUM_LEVELS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .src_in(src4),
        .WB_RD_STB_I(rd_stb & sel), .WB_RD_ADR_I(rd_adr), .WB_RD_DAT_O(rdat4), .WB_RD_ACK_O(rack4),
        .WB_WR_STB_I(wr_stb & sel), .WB_WR_WE_I(wr_we), .WB_WR_ADR_I(wr_adr), .WB_WR_DAT_I(wr_dat),
        .WB_WR_ACK_O(wack4), .int_gen(gen4), .int_addr(iaddr4),
        .interrupt_return(ret & sel), .int_active_level(lvl4)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [7:0] d, output logic ack);
        wr_stb = 1'b1; wr_we = 1'b1; wr_adr = a; wr_dat = d;
        step();
        ack = wack;
        wr_stb = 1'b0; wr_we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [7:0] d, output logic ack);
        rd_stb = 1'b1; rd_adr = a;
        step();
        d = rdat; ack = rack;
        rd_stb = 1'b0;
    endtask

    task automatic reti;
        ret = 1'b1;
        step();
        ret = 1'b0;
    endtask

    task automatic wait_gen(output int n, output logic found);
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            step();
            n++;
            if (gen === 1'b1) found = 1'b1;
        end
    endtask

    task automatic count_gen(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (gen === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset;
        logic ack; logic [7:0] d;
        reset_n = 1'b0;
        step(); step();
        checks++; if (gen1 !== 1'b0) begin failures++; $display("FAIL rst_gen got=%0h exp=0", gen1); end
        checks++; if (iaddr1 !== 8'h00) begin failures++; $display("FAIL rst_addr got=%0h exp=0", iaddr1); end
        checks++; if (lvl1 !== 2'b00) begin failures++; $display("FAIL rst_lvl got=%0h exp=0", lvl1); end
        checks++; if ({rack1, wack1, rdat1} !== 10'h000) begin failures++; $display("FAIL rst_wb got=%0h exp=0", {rack1, wack1, rdat1}); end
        reset_n = 1'b1;
        step();
        wb_read(8'hA8, d, ack);
        checks++; if ({ack, d} !== 9'h100) begin failures++; $display("FAIL rst_ie_read got=%0h exp=100", {ack, d}); end
    endtask

    task automatic test_edge_single;
        logic ack, found; logic [7:0] d; int n;
        wb_write(8'hA8, 8'h81, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL t1_ie_ack got=%0h exp=1", ack); end
        wb_write(8'hC8, 8'h01, ack);
        src1[0] = 1'b1;
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || n !== 5) begin failures++; $display("FAIL t1_latency got=%0d/%0d exp=1/5", found, n); end
        checks++; if (iaddr !== 8'h03) begin failures++; $display("FAIL t1_addr got=%0h exp=03", iaddr); end
        step();
        checks++; if (gen !== 1'b0) begin failures++; $display("FAIL t1_single_pulse got=%0h exp=0", gen); end
        checks++; if (lvl !== 3'b010) begin failures++; $display("FAIL t1_active got=%0h exp=2", lvl); end
        wb_read(8'hC9, d, ack);
        checks++; if ({ack, d} !== 9'h100) begin failures++; $display("FAIL t1_iflag_clr got=%0h exp=100", {ack, d}); end
        reti();
        checks++; if (lvl !== 3'b000) begin failures++; $display("FAIL t1_reti got=%0h exp=0", lvl); end
        src1[0] = 1'b0;
    endtask

    task automatic test_tie;
        logic ack, found; int n, p;
        wb_write(8'hC8, 8'h24, ack);
        wb_write(8'hA8, 8'hA4, ack);
        src1[2] = 1'b1; src1[5] = 1'b1;
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || iaddr !== 8'h13) begin failures++; $display("FAIL t2_first got=%0d/%0h exp=1/13", found, iaddr); end
        reti();  // same cycle as FIRE with ISR empty: ignored, then set
        checks++; if (lvl !== 3'b010) begin failures++; $display("FAIL t2_same_cycle got=%0h exp=2", lvl); end
        count_gen(10, p);
        checks++; if (p !== 0) begin failures++; $display("FAIL t2_wait got=%0d exp=0", p); end
        reti();
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || iaddr !== 8'h2B) begin failures++; $display("FAIL t2_second got=%0d/%0h exp=1/2b", found, iaddr); end
        step();
        reti();
        checks++; if (lvl !== 3'b000) begin failures++; $display("FAIL t2_done got=%0h exp=0", lvl); end
        src1[2] = 1'b0; src1[5] = 1'b0;
    endtask

    task automatic test_nesting;
        logic ack, found; int n;
        wb_write(8'hC8, 8'h42, ack);
        wb_write(8'hB8, 8'h40, ack);
        wb_write(8'hA8, 8'hC2, ack);
        src1[1] = 1'b1;
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || iaddr !== 8'h0B) begin failures++; $display("FAIL t3_low got=%0d/%0h exp=1/0b", found, iaddr); end
        step();
        checks++; if (lvl !== 3'b010) begin failures++; $display("FAIL t3_lvl0 got=%0h exp=2", lvl); end
        src1[6] = 1'b1;
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || iaddr !== 8'h33) begin failures++; $display("FAIL t3_nested got=%0d/%0h exp=1/33", found, iaddr); end
        step();
        checks++; if (lvl !== 3'b011) begin failures++; $display("FAIL t3_lvl1 got=%0h exp=3", lvl); end
        reti();
        checks++; if (lvl !== 3'b010) begin failures++; $display("FAIL t3_reti1 got=%0h exp=2", lvl); end
        reti();
        checks++; if (lvl !== 3'b000) begin failures++; $display("FAIL t3_reti2 got=%0h exp=0", lvl); end
        src1[1] = 1'b0; src1[6] = 1'b0;
    endtask

    task automatic test_level_ea;
        logic ack, found; int n, p;
        wb_write(8'hC8, 8'h00, ack);
        wb_write(8'hB8, 8'h00, ack);
        wb_write(8'hA8, 8'h08, ack);
        src1[3] = 1'b1;
        count_gen(10, p);
        checks++; if (p !== 0) begin failures++; $display("FAIL t4_ea_off got=%0d exp=0", p); end
        wb_write(8'hA8, 8'h88, ack);
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || iaddr !== 8'h1B) begin failures++; $display("FAIL t4_ea_on got=%0d/%0h exp=1/1b", found, iaddr); end
        step();
        count_gen(8, p);
        checks++; if (p !== 0) begin failures++; $display("FAIL t4_in_service got=%0d exp=0", p); end
        reti();
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || iaddr !== 8'h1B) begin failures++; $display("FAIL t4_rerequest got=%0d/%0h exp=1/1b", found, iaddr); end
        step();
        wb_write(8'hA8, 8'h08, ack);
        reti();
        count_gen(8, p);
        checks++; if (p !== 0) begin failures++; $display("FAIL t4_ea_off2 got=%0d exp=0", p); end
        src1[3] = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_sw_race;
        logic ack; logic [7:0] d;
        wb_write(8'hA8, 8'h00, ack);
        wb_write(8'hC8, 8'h10, ack);
        src1[4] = 1'b1;
        step(); step();
        wb_write(8'hC9, 8'h00, ack);  // lands on the same edge as the synchronised rise
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL t5_wr_ack got=%0h exp=1", ack); end
        wb_read(8'hC9, d, ack);
        checks++; if ({ack, d} !== 9'h110) begin failures++; $display("FAIL t5_race got=%0h exp=110", {ack, d}); end
        wb_write(8'hC9, 8'h00, ack);
        wb_read(8'hC9, d, ack);
        checks++; if ({ack, d} !== 9'h100) begin failures++; $display("FAIL t5_sw_clear got=%0h exp=100", {ack, d}); end
        wb_write(8'hC9, 8'h10, ack);
        wb_read(8'hC9, d, ack);
        checks++; if ({ack, d} !== 9'h110) begin failures++; $display("FAIL t5_sw_set got=%0h exp=110", {ack, d}); end
        wb_write(8'hC9, 8'h00, ack);
        src1[4] = 1'b0;
    endtask

    task automatic test_levels4;
        logic ack, found; logic [7:0] d; int n;
        wb_write(8'hB7, 8'hFF, ack);
        wb_read(8'hB7, d, ack);
        checks++; if ({ack, d} !== 9'h100) begin failures++; $display("FAIL t6_iph_2lvl got=%0h exp=100", {ack, d}); end
        sel = 1'b1;
        wb_write(8'hB7, 8'hFF, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL t6_iph_ack got=%0h exp=1", ack); end
        wb_read(8'hB7, d, ack);
        checks++; if ({ack, d} !== 9'h107) begin failures++; $display("FAIL t6_iph_read got=%0h exp=107", {ack, d}); end
        wb_write(8'h55, 8'hFF, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t6_unmapped_wr got=%0h exp=0", ack); end
        wb_read(8'h55, d, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t6_unmapped_rd got=%0h exp=0", ack); end
        wb_write(8'hA8, 8'h81, ack);
        wb_write(8'hC8, 8'h01, ack);
        src4[0] = 1'b1;
        wait_gen(n, found);
        checks++; if (found !== 1'b1 || iaddr !== 8'h03) begin failures++; $display("FAIL t6_gen got=%0d/%0h exp=1/03", found, iaddr); end
        step();
        checks++; if (lvl !== 3'b110) begin failures++; $display("FAIL t6_lvl2 got=%0h exp=6", lvl); end
        src4[0] = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if ({gen, iaddr, lvl} !== 12'h000) begin failures++; $display("FAIL t6_async_rst got=%0h exp=0", {gen, iaddr, lvl}); end
        #2;
        reset_n = 1'b1;
        step();
        wb_read(8'hB7, d, ack);
        checks++; if ({ack, d} !== 9'h100) begin failures++; $display("FAIL t6_iph_rst got=%0h exp=100", {ack, d}); end
        sel = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; src1 = 8'h00; src4 = 3'b000; sel = 1'b0;
        rd_stb = 1'b0; wr_stb = 1'b0; wr_we = 1'b0; ret = 1'b0;
        rd_adr = 8'h00; wr_adr = 8'h00; wr_dat = 8'h00;
        test_reset();
        test_edge_single();
        test_tie();
        test_nesting();
        test_level_ea();
        test_sw_race();
        test_levels4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
